// File: rtl/uart_rx_param.sv
// rtl/uart_rx_param.sv - parametrised UART receiver with valid/ack hold and overrun flag
// Optional: define UART_RX_MAJORITY_VOTE_EN for 2-of-3 majority sampling of every bit.
module uart_rx_param #(
    parameter int CLKS_PER_BAUD_PERIOD = 434,
    parameter int DATA_BITS            = 8,
    parameter int PARITY_MODE          = 0,
    parameter int STOP_BITS            = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_rx_data_line,
    input  logic                 i_data_ack,
    output logic                 o_data_valid,
    output logic [DATA_BITS-1:0] o_data_byte,
    output logic                 o_parity_err,
    output logic                 o_frame_err,
    output logic                 o_overrun,
    output logic                 o_busy
);

    localparam int CW = $clog2(CLKS_PER_BAUD_PERIOD);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] HALF = CW'((CLKS_PER_BAUD_PERIOD - 1) / 2);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BAUD_PERIOD - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_DELIVER, S_BREAK
    } state_t;

    state_t               state, state_next;
    logic                 rx_meta, rx_s, rx_bit;
    logic [CW-1:0]        clk_ctr;
    logic [BW-1:0]        bit_ctr;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 parity_bit, stop_low, parity_sum, parity_err;
    logic                 at_sample, sample_en, deliver;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= i_rx_data_line;
            rx_s    <= rx_meta;
        end
    end

`ifdef UART_RX_MAJORITY_VOTE_EN
    // rx_meta is the value rx_s takes next cycle, so the vote window centred on
    // the sample point is available without delaying the bit timing.
    logic rx_prev;
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) rx_prev <= 1'b1;
        else          rx_prev <= rx_s;
    end
    assign rx_bit = (rx_prev & rx_s) | (rx_prev & rx_meta) | (rx_s & rx_meta);
`else
    assign rx_bit = rx_s;
`endif

    assign at_sample = (clk_ctr == LAST);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) state <= S_IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:    if (!rx_s) state_next = S_START;
`ifdef UART_RX_MAJORITY_VOTE_EN
            S_START:   if (clk_ctr == HALF) state_next = rx_bit ? S_IDLE : S_DATA;
`else
            S_START:   if (rx_s) state_next = S_IDLE;
                       else if (clk_ctr == HALF) state_next = S_DATA;
`endif
            S_DATA:    if (at_sample && bit_ctr == BW'(DATA_BITS - 1))
                           state_next = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
            S_PARITY:  if (at_sample) state_next = S_STOP;
            S_STOP:    if (at_sample && bit_ctr == BW'(STOP_BITS - 1)) state_next = S_DELIVER;
            S_DELIVER: state_next = o_frame_err ? S_BREAK : S_IDLE;
            S_BREAK:   if (rx_s) state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    always_comb begin
        o_busy    = (state != S_IDLE);
        sample_en = at_sample && (state == S_DATA || state == S_PARITY || state == S_STOP);
        deliver   = at_sample && (state == S_STOP) && (bit_ctr == BW'(STOP_BITS - 1));
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            clk_ctr <= '0;
            bit_ctr <= '0;
        end else begin
            if (state_next != state || at_sample || state == S_IDLE || state == S_BREAK)
                clk_ctr <= '0;
            else
                clk_ctr <= clk_ctr + CW'(1);
            if (state_next != state) bit_ctr <= '0;
            else if (sample_en)      bit_ctr <= bit_ctr + BW'(1);
        end
    end

    assign parity_sum = ^{shift_reg, parity_bit};
    assign parity_err = (PARITY_MODE == 1) ? ~parity_sum :
                        (PARITY_MODE == 2) ?  parity_sum : 1'b0;

    // Outputs load on the last stop sample so they are visible during DELIVER.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            shift_reg    <= '0;
            parity_bit   <= 1'b0;
            stop_low     <= 1'b0;
            o_data_valid <= 1'b0;
            o_data_byte  <= '0;
            o_parity_err <= 1'b0;
            o_frame_err  <= 1'b0;
            o_overrun    <= 1'b0;
        end else begin
            if (state == S_IDLE) stop_low <= 1'b0;
            if (sample_en && state == S_DATA)   shift_reg  <= {rx_bit, shift_reg[DATA_BITS-1:1]};
            if (sample_en && state == S_PARITY) parity_bit <= rx_bit;
            if (sample_en && state == S_STOP && !rx_bit) stop_low <= 1'b1;

            if (deliver) begin
                o_data_byte  <= shift_reg;
                o_parity_err <= parity_err;
                o_frame_err  <= stop_low | ~rx_bit;
                o_data_valid <= 1'b1;
                if (o_data_valid && !i_data_ack) o_overrun <= 1'b1;
                else if (o_data_valid)           o_overrun <= 1'b0;
            end else if (o_data_valid && i_data_ack) begin
                o_data_valid <= 1'b0;
                o_overrun    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_param.sv
// tb/tb_uart_rx_param.sv - randomized and directed checks of uart_rx_param against a frame-level model
module tb_uart_rx_param;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx  [3];
    logic       ack [3];
    logic       valid [3];
    logic       perr  [3];
    logic       ferr  [3];
    logic       ovr   [3];
    logic       busy  [3];
    logic [7:0] data_a, data_b;
    logic [8:0] data_c;

    int compared = 0;
    int mismatched = 0;
    bit exp_valid [3];
    bit exp_ovr   [3];

    always #5 clk = ~clk;

    uart_rx_param #(.CLKS_PER_BAUD_PERIOD(CPB)) dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_rx_data_line(rx[0]), .i_data_ack(ack[0]),
        .o_data_valid(valid[0]), .o_data_byte(data_a), .o_parity_err(perr[0]),
        .o_frame_err(ferr[0]), .o_overrun(ovr[0]), .o_busy(busy[0]));

    uart_rx_param #(.CLKS_PER_BAUD_PERIOD(CPB), .PARITY_MODE(2)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_rx_data_line(rx[1]), .i_data_ack(ack[1]),
        .o_data_valid(valid[1]), .o_data_byte(data_b), .o_parity_err(perr[1]),
        .o_frame_err(ferr[1]), .o_overrun(ovr[1]), .o_busy(busy[1]));

    uart_rx_param #(.CLKS_PER_BAUD_PERIOD(CPB), .DATA_BITS(9), .STOP_BITS(2)) dut_c (
        .i_clk(clk), .i_rst_n(rst_n), .i_rx_data_line(rx[2]), .i_data_ack(ack[2]),
        .o_data_valid(valid[2]), .o_data_byte(data_c), .o_parity_err(perr[2]),
        .o_frame_err(ferr[2]), .o_overrun(ovr[2]), .o_busy(busy[2]));

    function automatic int nbits(input int idx);
        return (idx == 2) ? 9 : 8;
    endfunction

    function automatic int pmode(input int idx);
        return (idx == 1) ? 2 : 0;
    endfunction

    function automatic int nstop(input int idx);
        return (idx == 2) ? 2 : 1;
    endfunction

    function automatic logic [8:0] dout(input int idx);
        case (idx)
            0:       return {1'b0, data_a};
            1:       return {1'b0, data_b};
            default: return data_c;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives the first count bits of a frame (count < 0: whole frame), 16 cycles per bit.
    task automatic send_bits(input int idx, input int v, input bit p, input bit [1:0] s, input int count);
        bit fb[$];
        int n;
        fb.push_back(1'b0);
        for (int i = 0; i < nbits(idx); i++) fb.push_back(bit'((v >> i) & 1));
        if (pmode(idx) != 0) fb.push_back(p);
        for (int i = 0; i < nstop(idx); i++) fb.push_back(s[i]);
        n = (count < 0) ? fb.size() : count;
        for (int k = 0; k < n; k++) begin
            rx[idx] = fb[k];
            tick(CPB);
        end
    endtask

    task automatic check_idle_outputs(input int idx, input string tag);
        chk({tag, "_valid"}, 16'(valid[idx]), 16'(0));
        chk({tag, "_data"},  16'(dout(idx)),  16'(0));
        chk({tag, "_perr"},  16'(perr[idx]),  16'(0));
        chk({tag, "_ferr"},  16'(ferr[idx]),  16'(0));
        chk({tag, "_ovr"},   16'(ovr[idx]),   16'(0));
        chk({tag, "_busy"},  16'(busy[idx]),  16'(0));
    endtask

    // Sends a full frame and checks the delivered word against the frame-level model.
    task automatic frame(input int idx, input int v, input bit p, input bit [1:0] s, input string tag);
        int mask, ones, n;
        bit e_perr, e_ferr;
        mask = (1 << nbits(idx)) - 1;
        ones = $countones(v & mask) + int'(p);
        e_perr = (pmode(idx) == 1) ? (ones % 2 == 0) :
                 (pmode(idx) == 2) ? (ones % 2 == 1) : 1'b0;
        e_ferr = (s[0] == 1'b0) || (nstop(idx) == 2 && s[1] == 1'b0);
        send_bits(idx, v, p, s, -1);
        n = 0;
        while (valid[idx] !== 1'b1 && n < 60) begin
            tick(1);
            n++;
        end
        exp_ovr[idx]   = exp_ovr[idx] | exp_valid[idx];
        exp_valid[idx] = 1'b1;
        chk({tag, "_valid"}, 16'(valid[idx]), 16'(exp_valid[idx]));
        chk({tag, "_data"},  16'(dout(idx)),  16'(v & mask));
        chk({tag, "_perr"},  16'(perr[idx]),  16'(e_perr));
        chk({tag, "_ferr"},  16'(ferr[idx]),  16'(e_ferr));
        chk({tag, "_ovr"},   16'(ovr[idx]),   16'(exp_ovr[idx]));
    endtask

    task automatic do_ack(input int idx, input int delay, input string tag);
        tick(delay);
        ack[idx] = 1'b1;
        tick(1);
        ack[idx] = 1'b0;
        exp_valid[idx] = 1'b0;
        exp_ovr[idx]   = 1'b0;
        chk({tag, "_ack_valid"}, 16'(valid[idx]), 16'(exp_valid[idx]));
        chk({tag, "_ack_ovr"},   16'(ovr[idx]),   16'(exp_ovr[idx]));
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp_valid[i] = 1'b0;
            exp_ovr[i]   = 1'b0;
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            rx[i] = 1'b1;
            ack[i] = 1'b0;
            exp_valid[i] = 1'b0;
            exp_ovr[i] = 1'b0;
        end
        tick(3);
        rst_n = 1'b1;
        check_idle_outputs(0, "reset_a");
        check_idle_outputs(2, "reset_c");
        tick(4);

        // 8N1 basic word, ack three cycles after valid
        frame(0, 'hA5, 1'b0, 2'b11, "t1");
        do_ack(0, 3, "t1");

        // short low glitch must not start a frame
        rx[0] = 1'b0;
        tick(4);
        rx[0] = 1'b1;
        tick(20);
        chk("t2_glitch_busy",  16'(busy[0]),  16'(0));
        chk("t2_glitch_valid", 16'(valid[0]), 16'(0));
        frame(0, 'h3C, 1'b0, 2'b11, "t2");
        do_ack(0, 1, "t2");

        // even parity
        frame(1, 'h03, 1'b1, 2'b11, "t3a");
        do_ack(1, 0, "t3a");
        tick(4);
        frame(1, 'h03, 1'b0, 2'b11, "t3b");
        do_ack(1, 0, "t3b");

        // framing error followed by a held-low line
        frame(0, 'h55, 1'b0, 2'b00, "t4a");
        do_ack(0, 0, "t4a");
        tick(40);
        chk("t4_hold_valid", 16'(valid[0]), 16'(0));
        chk("t4_hold_busy",  16'(busy[0]),  16'(1));
        rx[0] = 1'b1;
        tick(5);
        chk("t4_release_busy", 16'(busy[0]), 16'(0));
        frame(0, 'h81, 1'b0, 2'b11, "t4b");
        do_ack(0, 0, "t4b");

        // overrun
        tick(4);
        frame(0, 'h11, 1'b0, 2'b11, "t5a");
        tick(4);
        frame(0, 'h22, 1'b0, 2'b11, "t5b");
        do_ack(0, 2, "t5");

        // reset mid-data aborts the frame
        tick(4);
        send_bits(0, 'hF0, 1'b0, 2'b11, 4);
        pulse_reset();
        rx[0] = 1'b1;
        check_idle_outputs(0, "t6a_rst");
        tick(12 * CPB);
        chk("t6a_no_partial", 16'(valid[0]), 16'(0));
        frame(0, 'h0F, 1'b0, 2'b11, "t6a");
        do_ack(0, 0, "t6a");

        tick(4);
        send_bits(2, 'h0F0, 1'b0, 2'b11, 6);
        pulse_reset();
        rx[2] = 1'b1;
        check_idle_outputs(2, "t6b_rst");
        tick(14 * CPB);
        chk("t6b_no_partial", 16'(valid[2]), 16'(0));
        frame(2, 'h1AB, 1'b0, 2'b11, "t6b");
        do_ack(2, 0, "t6b");

        // randomized frames on every configuration, random stop errors and ack policy
        for (int idx = 0; idx < 3; idx++) begin
            for (int k = 0; k < 6; k++) begin
                int v;
                bit p;
                bit [1:0] s;
                v = int'($urandom_range(0, 511));
                p = bit'($urandom_range(0, 1));
                s[0] = ($urandom_range(0, 5) != 0);
                s[1] = ($urandom_range(0, 5) != 0);
                frame(idx, v, p, s, $sformatf("rnd%0d_%0d", idx, k));
                rx[idx] = 1'b1;
                if ($urandom_range(0, 1) == 1)
                    do_ack(idx, int'($urandom_range(0, 3)), $sformatf("rnd%0d_%0d", idx, k));
                tick(int'($urandom_range(3, 8)));
            end
            if (exp_valid[idx]) do_ack(idx, 0, $sformatf("rnd%0d_end", idx));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
